store_rmw_unit: RTL and testbench



---
 rtl/store_rmw_unit.sv | 108 ++++++++++
 tb/tb_store_rmw_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_unit.sv
// Sub-word store engine for a byte-enable-less memory: sw writes directly, sb/sh read-merge-write.
// Latency sw=2, sb/sh=READ_LATENCY+2, error=1 cycles; st_ready is low until the FSM returns to IDLE.
module store_rmw_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        st_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
    logic [2:0]  funct3;
  } req_t;

  localparam logic [2:0] F_SB   = 3'b000;
  localparam logic [2:0] F_SH   = 3'b001;
  localparam logic [2:0] F_SW   = 3'b010;
  localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

  state_t      state, state_nx;
  req_t        req;
  logic [2:0]  cnt;
  logic [31:0] wdata_q;
  logic [31:0] merged;
  logic        accept;
  logic        bad_req;

  assign accept = st_valid && st_ready;

  always_comb begin
    bad_req = 1'b0;
    case (st_funct3)
      F_SB:    bad_req = 1'b0;
      F_SH:    bad_req = st_addr[0];
      F_SW:    bad_req = |st_addr[1:0];
      default: bad_req = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (st_valid) begin
          if (bad_req)                state_nx = S_ERR;
          else if (st_funct3 == F_SW) state_nx = S_WR;
          else                        state_nx = S_RD;
        end
      end
      S_RD:    if (cnt == 3'd0) state_nx = S_WR;
      S_WR:    state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Little-endian lane splice of the latched store data into the fetched word.
  always_comb begin
    merged = mem_rdata;
    if (req.funct3 == F_SB)
      merged[{req.addr[1:0], 3'b000} +: 8] = req.data[7:0];
    else
      merged[{req.addr[1], 4'b0000} +: 16] = req.data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      req     <= '0;
      cnt     <= 3'd0;
      wdata_q <= 32'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req     <= '{addr: st_addr, data: st_data[15:0], funct3: st_funct3};
        cnt     <= LAT_M1;
        wdata_q <= st_data;
      end else if (state == S_RD) begin
        if (cnt == 3'd0) wdata_q <= merged;
        else             cnt     <= cnt - 3'd1;
      end
    end
  end

  assign st_ready  = (state == S_IDLE);
  assign st_done   = (state == S_DONE);
  assign st_err    = (state == S_ERR);
  assign mem_we    = (state == S_WR);
  assign mem_wdata = (state == S_WR) ? wdata_q : 32'd0;
  assign mem_addr  = (state == S_RD || state == S_WR || state == S_DONE) ?
                     {req.addr[31:2], 2'b00} : 32'd0;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: one instance at READ_LATENCY=1, one at 3, each with its own memory model.
module tb_store_rmw_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] sa = 32'd0, sd = 32'd0;
  logic        v1 = 1'b0, v3 = 1'b0;
  logic        rdy1, done1, err1, we1;
  logic        rdy3, done3, err3, we3;
  logic [31:0] a1, wd1, rd1, a3, wd3, rd3;

  store_rmw_unit #(.READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .st_valid(v1), .st_ready(rdy1), .st_funct3(f3),
    .st_addr(sa), .st_data(sd), .st_done(done1), .st_err(err1),
    .mem_addr(a1), .mem_we(we1), .mem_wdata(wd1), .mem_rdata(rd1));

  store_rmw_unit #(.READ_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .st_valid(v3), .st_ready(rdy3), .st_funct3(f3),
    .st_addr(sa), .st_data(sd), .st_done(done3), .st_err(err3),
    .mem_addr(a3), .mem_we(we3), .mem_wdata(wd3), .mem_rdata(rd3));

  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic        pl1 = 1'b0, pl3 = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_dat = 32'd0;
  logic [31:0] p0, p1;

  // Latency-3 memory: two register stages behind the combinational array read.
  always @(posedge clk) begin
    if (we1) mem1[a1[7:2]] <= wd1; else if (pl1) mem1[pl_idx] <= pl_dat;
    if (we3) mem3[a3[7:2]] <= wd3; else if (pl3) mem3[pl_idx] <= pl_dat;
    p0 <= mem3[a3[7:2]];
    p1 <= p0;
  end
  assign rd1 = mem1[a1[7:2]];
  assign rd3 = p1;

  wr_t q1[$];
  wr_t q3[$];
  wr_t e1, e3;
  int  errors = 0;
  int  checks = 0;

  always @(negedge clk) begin
    if (we1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++; $display("FAIL u1_write unexpected addr=%h data=%h", a1, wd1);
      end else begin
        e1 = q1.pop_front();
        if (a1 !== e1.addr || wd1 !== e1.data) begin
          errors++; $display("FAIL u1_write addr=%h data=%h expected addr=%h data=%h", a1, wd1, e1.addr, e1.data);
        end
      end
    end
    if (we3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++; $display("FAIL u3_write unexpected addr=%h data=%h", a3, wd3);
      end else begin
        e3 = q3.pop_front();
        if (a3 !== e3.addr || wd3 !== e3.data) begin
          errors++; $display("FAIL u3_write addr=%h data=%h expected addr=%h data=%h", a3, wd3, e3.addr, e3.data);
        end
      end
    end
  end

  task automatic preload(input bit s3, input logic [31:0] addr, input logic [31:0] dat);
    @(negedge clk);
    pl_idx = addr[7:2]; pl_dat = dat;
    if (s3) pl3 = 1'b1; else pl1 = 1'b1;
    @(negedge clk);
    pl1 = 1'b0; pl3 = 1'b0;
  endtask

  function automatic logic [31:0] peek(input bit s3, input logic [31:0] addr);
    return s3 ? mem3[addr[7:2]] : mem1[addr[7:2]];
  endfunction

  // Called at a negedge; the request is accepted on the following posedge, then inputs are scrambled.
  task automatic issue(input bit s3, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d);
    f3 = fn; sa = a; sd = d;
    if (s3) v3 = 1'b1; else v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0; v3 = 1'b0;
    sa = $urandom; sd = $urandom; f3 = 3'($urandom);
  endtask

  task automatic observe(input bit s3, output logic c1_ready, output logic [31:0] c1_addr,
                         output int we_cyc, output int done_cyc, output int done_n,
                         output int err_cyc, output int err_n, output int end_cyc);
    c1_ready = 1'bx; c1_addr = 'x;
    we_cyc = 0; done_cyc = 0; done_n = 0; err_cyc = 0; err_n = 0; end_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin c1_ready = s3 ? rdy3 : rdy1; c1_addr = s3 ? a3 : a1; end
      if ((s3 ? we3 : we1) && we_cyc == 0) we_cyc = c;
      if (s3 ? done3 : done1) begin done_n++; if (done_cyc == 0) done_cyc = c; end
      if (s3 ? err3 : err1) begin err_n++; if (err_cyc == 0) err_cyc = c; end
      if (s3 ? rdy3 : rdy1) begin end_cyc = c; break; end
    end
  endtask

  logic        c1r;
  logic [31:0] c1a;
  int          wc, dc, dn, ec, en, nc;

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", rdy1); end
    checks++; if ({done1, err1, we1} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b want=000", {done1, err1, we1}); end
    checks++; if (a1 !== 32'd0 || wd1 !== 32'd0) begin errors++; $display("FAIL reset_mem_bus addr=%h wdata=%h want 0", a1, wd1); end
    checks++; if (rdy3 !== 1'b1 || a3 !== 32'd0) begin errors++; $display("FAIL reset_u3 ready=%b addr=%h", rdy3, a3); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sb_basic;
    preload(0, 32'ha0, 32'h44332211);
    q1.push_back(wr_t'{32'h000000a0, 32'h4433AB11});
    issue(0, SB, 32'ha1, 32'hFFFFFFAB);
    observe(0, c1r, c1a, wc, dc, dn, ec, en, nc);
    checks++; if (c1a !== 32'ha0 || c1r !== 1'b0) begin errors++; $display("FAIL sb_rd_cycle addr=%h ready=%b want a0/0", c1a, c1r); end
    checks++; if (wc !== 2 || dc !== 3 || dn !== 1 || nc !== 4) begin errors++; $display("FAIL sb_latency we=%0d done=%0d n=%0d idle=%0d want 2/3/1/4", wc, dc, dn, nc); end
    checks++; if (peek(0, 32'ha0) !== 32'h4433AB11) begin errors++; $display("FAIL sb_readback got=%h want=4433ab11", peek(0, 32'ha0)); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] ad, exp_w;
    for (int k = 0; k < 4; k++) preload(0, 32'hb0 + 32'(4 * k), 32'd0);
    for (int k = 0; k < 4; k++) begin
      ad    = 32'hb0 + 32'(5 * k);
      exp_w = 32'h5A << (8 * k);
      q1.push_back(wr_t'{{ad[31:2], 2'b00}, exp_w});
      issue(0, SB, ad, 32'hC3C3C35A);
      observe(0, c1r, c1a, wc, dc, dn, ec, en, nc);
      checks++; if (dc !== 3 || peek(0, ad) !== exp_w) begin errors++; $display("FAIL sb_lane%0d word=%h done=%0d want %h/3", k, peek(0, ad), dc, exp_w); end
    end
  endtask

  task automatic test_halfword;
    preload(0, 32'ha8, 32'hc7d6e5f4);
    q1.push_back(wr_t'{32'h000000a8, 32'h1234e5f4});
    issue(0, SH, 32'haa, 32'h55551234);
    observe(0, c1r, c1a, wc, dc, dn, ec, en, nc);
    checks++; if (peek(0, 32'ha8) !== 32'h1234e5f4 || dc !== 3) begin errors++; $display("FAIL sh_upper word=%h done=%0d want 1234e5f4/3", peek(0, 32'ha8), dc); end
    q1.push_back(wr_t'{32'h000000a8, 32'h1234BEEF});
    issue(0, SH, 32'ha8, 32'hAAAABEEF);
    observe(0, c1r, c1a, wc, dc, dn, ec, en, nc);
    checks++; if (peek(0, 32'ha8) !== 32'h1234BEEF || dc !== 3) begin errors++; $display("FAIL sh_lower word=%h done=%0d want 1234beef/3", peek(0, 32'ha8), dc); end
  endtask

  task automatic test_word;
    q1.push_back(wr_t'{32'h000000a8, 32'hDEADBEEF});
    issue(0, SW, 32'ha8, 32'hDEADBEEF);
    observe(0, c1r, c1a, wc, dc, dn, ec, en, nc);
    checks++; if (wc !== 1 || dc !== 2 || nc !== 3) begin errors++; $display("FAIL sw_latency we=%0d done=%0d idle=%0d want 1/2/3", wc, dc, nc); end
    checks++; if (peek(0, 32'ha8) !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_readback got=%h want=deadbeef", peek(0, 32'ha8)); end
  endtask

  task automatic test_errors;
    logic [2:0]  fns [3] = '{SH, SW, 3'b011};
    logic [31:0] ads [3] = '{32'ha1, 32'ha2, 32'ha0};
    for (int i = 0; i < 3; i++) begin
      issue(0, fns[i], ads[i], 32'h99999999);
      observe(0, c1r, c1a, wc, dc, dn, ec, en, nc);
      checks++; if (ec !== 1 || en !== 1 || nc !== 2) begin errors++; $display("FAIL err%0d_pulse cyc=%0d n=%0d idle=%0d want 1/1/2", i, ec, en, nc); end
      checks++; if (wc !== 0 || dn !== 0 || peek(0, 32'ha0) !== 32'h4433AB11) begin errors++; $display("FAIL err%0d_side we=%0d done=%0d word=%h want 0/0/4433ab11", i, wc, dn, peek(0, 32'ha0)); end
    end
  endtask

  task automatic test_reset_midop;
    int bad_n;
    preload(1, 32'h0, 32'h0F0F0F0F);
    preload(1, 32'ha0, 32'h44332211);
    issue(1, SB, 32'ha2, 32'h00000077);
    @(negedge clk);
    checks++; if (rdy3 !== 1'b0 || a3 !== 32'ha0) begin errors++; $display("FAIL rst_rd1 ready=%b addr=%h want 0/a0", rdy3, a3); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (rdy3 !== 1'b1 || a3 !== 32'd0) begin errors++; $display("FAIL rst_idle ready=%b addr=%h want 1/0", rdy3, a3); end
    bad_n = 0;
    repeat (5) begin
      if (done3 || we3) bad_n++;
      @(negedge clk);
    end
    checks++; if (bad_n !== 0 || peek(1, 32'ha0) !== 32'h44332211) begin errors++; $display("FAIL rst_no_write events=%0d word=%h want 0/44332211", bad_n, peek(1, 32'ha0)); end
    q3.push_back(wr_t'{32'h000000a0, 32'h44772211});
    issue(1, SB, 32'ha2, 32'h00000077);
    observe(1, c1r, c1a, wc, dc, dn, ec, en, nc);
    checks++; if (wc !== 4 || dc !== 5 || dn !== 1 || nc !== 6) begin errors++; $display("FAIL l3_latency we=%0d done=%0d n=%0d idle=%0d want 4/5/1/6", wc, dc, dn, nc); end
    checks++; if (peek(1, 32'ha0) !== 32'h44772211) begin errors++; $display("FAIL l3_readback got=%h want=44772211", peek(1, 32'ha0)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sb_basic();
    test_byte_lanes();
    test_halfword();
    test_word();
    test_errors();
    test_reset_midop();
    repeat (2) @(negedge clk);
    checks++; if (q1.size() != 0 || q3.size() != 0) begin errors++; $display("FAIL missing_writes u1=%0d u3=%0d want 0/0", q1.size(), q3.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
